pwm_multi: RTL and testbench
============================

PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter W, default 16: counter, period and duty width.
REQ-002 Parameter N, default 4: number of PWM channels sharing one timebase.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 en_i  input  1  count enable; low = counter, direction, outputs and active registers hold.
REQ-006 clr_i  input  1  synchronous clear/restart.
REQ-007 prd_we_i  input  1  write prd_i, mode_i, pol_i into shadow config.
REQ-008 prd_i  input  W  period value P.
REQ-009 mode_i  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-010 pol_i  input  N  per-channel polarity; 1 = inverted output.
REQ-011 dty_we_i  input  N  per-channel duty write mask.
REQ-012 dty_i  input  W  duty value D, written to every channel whose mask bit is set.
REQ-013 cnt_o  output  W  current counter value.
REQ-014 pwm_o  output  N  PWM outputs.
REQ-015 prd_end_o  output  1  one-cycle period-boundary pulse.

Function
REQ-016 Writes SHALL update shadow registers only; active registers (P_act, D_act[k], mode_act, pol_act) SHALL load from shadow solely at a period boundary or on clr_i.
REQ-017 Edge mode with P_act>0: counter SHALL count 0..P_act-1 and wrap to 0, one step per en_i cycle; boundary = enabled cycle with cnt==P_act-1.
REQ-018 Center mode with P_act>0: counter SHALL count up 0..P_act-1, repeat P_act-1 while switching to down, count down to 0, repeat 0 while switching to up (2*P_act cycles per period); boundary = enabled cycle with cnt==0 and direction down.
REQ-019 P_act==0: counter SHALL hold 0, direction up, pwm_o SHALL equal pol_act, and every enabled cycle SHALL be a boundary.
REQ-020 pwm_o[k] SHALL equal pol_act[k] XOR (cnt < D_act[k]), decoded from registered state only, same cycle as cnt_o.
REQ-021 D_act[k]==0 SHALL give constant inactive level; D_act[k]>=P_act (P_act>0) SHALL give constant active level; unsigned W-bit compare, no saturation logic beyond that.
REQ-022 At a boundary the next counter value SHALL be 0 and direction up, computed with the newly loaded mode_act.
REQ-023 prd_end_o SHALL be registered and high for exactly the cycle following each boundary edge, low otherwise.
REQ-024 clr_i SHALL have priority over en_i: counter to 0, direction up, active registers load from shadow, prd_end_o low next cycle.
REQ-025 Writes coinciding with a boundary or clr_i SHALL land in shadow only; the transfer in that cycle SHALL use pre-write shadow values.
REQ-026 Simultaneous prd_we_i and dty_we_i SHALL both be accepted in the same cycle.
REQ-027 Counter arithmetic SHALL be W-bit; it SHALL never exceed P_act-1, including when P_act shrinks (new P applies only from the next boundary).

Reset
REQ-028 rst_i SHALL immediately, without clock, clear cnt, direction (up), all shadow and active registers (P=0, D=0, mode edge, pol 0) and prd_end_o.
REQ-029 During and after reset pwm_o SHALL be 0, cnt_o 0, prd_end_o 0.
REQ-030 Reset asserted mid-period SHALL abort the period; no pending shadow value SHALL survive.

Verification
REQ-031 Reset: apply rst_i with no clock edges -> pwm_o=0, cnt_o=0, prd_end_o=0.
REQ-032 Edge: P=10, D0=3, pol=0, clr_i, en_i high -> pwm_o[0] high 3, low 7 cycles, repeating; prd_end_o every 10 cycles.
REQ-033 Shadow: write D0=7 at cnt=4 -> duty 3 remains to period end, duty 7 from next cnt=0.
REQ-034 Limits: P=10, D0=0, D1=12, pol=4'b0100, D2=5 -> pwm_o[0] always 0, pwm_o[1] always 1, pwm_o[2] low 5, high 5.
REQ-035 Center: P=5, D0=2 -> cnt 0,1,2,3,4,4,3,2,1,0 repeating; pwm_o[0] high at cnt 0,1 in both phases (4 of 10); prd_end_o every 10.
REQ-036 en_i low 3 cycles mid-period then high -> cnt and pwm_o frozen, period resumes, no extra prd_end_o; rst_i mid-period -> REQ-028 state asynchronously.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM sharing one edge/center-aligned timebase.
// Period, mode, polarity and duty are double-buffered and take effect at a period boundary or on clear.
//
// dir state | meaning
// DIR_UP    | counting up (edge mode always stays here)
// DIR_DN    | center mode, counting down toward the boundary at 0
module pwm_multi #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         prd_we_i,
    input  logic [W-1:0] prd_i,
    input  logic         mode_i,
    input  logic [N-1:0] pol_i,
    input  logic [N-1:0] dty_we_i,
    input  logic [W-1:0] dty_i,
    output logic [W-1:0] cnt_o,
    output logic [N-1:0] pwm_o,
    output logic         prd_end_o
);

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    dir_t         dir_q, dir_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         prd_end_q;
    logic         bnd;
    logic         load_act;

    logic [W-1:0] prd_sh, prd_act;
    logic         mode_sh, mode_act;
    logic [N-1:0] pol_sh, pol_act;
    logic [W-1:0] dty_sh  [N];
    logic [W-1:0] dty_act [N];

    logic [W-1:0] prd_m1;
    assign prd_m1 = prd_act - ONE;

    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        bnd      = 1'b0;
        load_act = 1'b0;
        if (clr_i) begin
            cnt_d    = '0;
            dir_d    = DIR_UP;
            load_act = 1'b1;
        end else if (en_i) begin
            if (prd_act == '0)
                bnd = 1'b1;
            else if (!mode_act)
                bnd = (cnt_q == prd_m1);
            else
                bnd = (dir_q == DIR_DN) && (cnt_q == '0);

            if (bnd) begin
                cnt_d    = '0;
                dir_d    = DIR_UP;
                load_act = 1'b1;
            end else if (dir_q == DIR_DN) begin
                cnt_d = cnt_q - ONE;
            end else if (mode_act && (cnt_q == prd_m1)) begin
                // center mode repeats the top value while turning around
                dir_d = DIR_DN;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            dir_q     <= DIR_UP;
            prd_end_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            prd_end_q <= bnd;
        end
    end

    // Transfer reads the shadow before this cycle's writes land in it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prd_sh   <= '0;
            mode_sh  <= 1'b0;
            pol_sh   <= '0;
            prd_act  <= '0;
            mode_act <= 1'b0;
            pol_act  <= '0;
            for (int k = 0; k < N; k++) begin
                dty_sh[k]  <= '0;
                dty_act[k] <= '0;
            end
        end else begin
            if (load_act) begin
                prd_act  <= prd_sh;
                mode_act <= mode_sh;
                pol_act  <= pol_sh;
                for (int k = 0; k < N; k++)
                    dty_act[k] <= dty_sh[k];
            end
            if (prd_we_i) begin
                prd_sh  <= prd_i;
                mode_sh <= mode_i;
                pol_sh  <= pol_i;
            end
            for (int k = 0; k < N; k++)
                if (dty_we_i[k])
                    dty_sh[k] <= dty_i;
        end
    end

    always_comb begin
        pwm_o = pol_act;
        for (int k = 0; k < N; k++)
            pwm_o[k] = pol_act[k] ^ ((prd_act != '0) && (cnt_q < dty_act[k]));
    end

    assign cnt_o     = cnt_q;
    assign prd_end_o = prd_end_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a phase-position reference model predicts every cycle,
// a monitor compares DUT outputs one time step after each rising edge.
module tb_pwm_multi;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         en_i = 1'b0;
    logic         clr_i = 1'b0;
    logic         prd_we_i = 1'b0;
    logic [W-1:0] prd_i = '0;
    logic         mode_i = 1'b0;
    logic [N-1:0] pol_i = '0;
    logic [N-1:0] dty_we_i = '0;
    logic [W-1:0] dty_i = '0;
    logic [W-1:0] cnt_o;
    logic [N-1:0] pwm_o;
    logic         prd_end_o;

    pwm_multi #(.W(W), .N(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i),
        .prd_we_i(prd_we_i), .prd_i(prd_i), .mode_i(mode_i), .pol_i(pol_i),
        .dty_we_i(dty_we_i), .dty_i(dty_i),
        .cnt_o(cnt_o), .pwm_o(pwm_o), .prd_end_o(prd_end_o)
    );

    bit clk_go = 1'b0;
    initial begin
        wait (clk_go);
        forever #5 clk_i = ~clk_i;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: position within the period rather than counter/direction.
    int       sh_p, ac_p;
    bit       sh_m, ac_m;
    bit [N-1:0] sh_pol, ac_pol;
    int       sh_d [N];
    int       ac_d [N];
    int       pos;
    bit       pe;

    typedef struct {
        int cnt;
        int pwm;
        int pe;
    } exp_t;
    exp_t q[$];

    function automatic int plen();
        if (ac_p == 0) return 1;
        return ac_m ? 2 * ac_p : ac_p;
    endfunction

    function automatic int mcnt();
        if (ac_p == 0) return 0;
        if (!ac_m || pos < ac_p) return pos;
        return 2 * ac_p - 1 - pos;
    endfunction

    function automatic void mload();
        ac_p = sh_p; ac_m = sh_m; ac_pol = sh_pol;
        for (int k = 0; k < N; k++) ac_d[k] = sh_d[k];
    endfunction

    function automatic void mreset();
        sh_p = 0; ac_p = 0; sh_m = 0; ac_m = 0; sh_pol = '0; ac_pol = '0;
        for (int k = 0; k < N; k++) begin sh_d[k] = 0; ac_d[k] = 0; end
        pos = 0; pe = 0;
    endfunction

    function automatic exp_t mexp();
        exp_t e;
        int   c;
        c = mcnt();
        e.cnt = c;
        e.pwm = 0;
        for (int k = 0; k < N; k++)
            if (ac_pol[k] ^ (ac_p > 0 && c < ac_d[k])) e.pwm |= (1 << k);
        e.pe = pe;
        return e;
    endfunction

    function automatic void mstep(input bit en, input bit clr, input bit pwe, input int prd,
                                  input bit md, input bit [N-1:0] pl, input bit [N-1:0] dwe,
                                  input int d);
        if (clr) begin
            mload(); pos = 0; pe = 0;
        end else if (en) begin
            pe = (pos == plen() - 1);
            if (pe) begin mload(); pos = 0; end
            else pos++;
        end else begin
            pe = 0;
        end
        if (pwe) begin sh_p = prd; sh_m = md; sh_pol = pl; end
        for (int k = 0; k < N; k++) if (dwe[k]) sh_d[k] = d;
    endfunction

    // Monitor: one expected entry per rising edge.
    exp_t em;
    always @(posedge clk_i) begin
        #1;
        if (q.size() > 0) begin
            em = q.pop_front();
            chk("cnt_o", int'(cnt_o), em.cnt);
            chk("pwm_o", int'(pwm_o), em.pwm);
            chk("prd_end_o", int'(prd_end_o), em.pe);
        end
    end

    int obs_hi [N];
    int obs_pe;

    task automatic obs_clear();
        for (int k = 0; k < N; k++) obs_hi[k] = 0;
        obs_pe = 0;
    endtask

    task automatic cyc(input bit en, input bit clr, input bit pwe, input int prd, input bit md,
                       input bit [N-1:0] pl, input bit [N-1:0] dwe, input int d);
        @(negedge clk_i);
        for (int k = 0; k < N; k++) if (pwm_o[k]) obs_hi[k]++;
        if (prd_end_o) obs_pe++;
        en_i = en; clr_i = clr; prd_we_i = pwe; prd_i = W'(prd); mode_i = md;
        pol_i = pl; dty_we_i = dwe; dty_i = W'(d);
        mstep(en, clr, pwe, prd, md, pl, dwe, d);
        q.push_back(mexp());
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) cyc(en, 0, 0, 0, 0, '0, '0, 0);
    endtask

    initial begin
        mreset();
        // reset with no clock edges
        #1 rst_i = 1'b1;
        #2;
        chk("rst_pwm", int'(pwm_o), 0);
        chk("rst_cnt", int'(cnt_o), 0);
        chk("rst_prd_end", int'(prd_end_o), 0);
        clk_go = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // edge mode P=10 D0=3, period and duty written together
        cyc(0, 0, 1, 10, 0, 4'b0000, 4'b0001, 3);
        cyc(1, 1, 0, 0, 0, '0, '0, 0);
        obs_clear();
        run(30, 1);
        chk("edge_hi_count", obs_hi[0], 9);
        chk("edge_pe_count", obs_pe, 2);

        // shadow duty written at cnt=4
        run(4, 1);
        cyc(1, 0, 0, 0, 0, '0, 4'b0001, 7);
        obs_clear();
        run(20, 1);
        chk("shadow_hi_count", obs_hi[0], 12);

        // duty limits and inverted polarity
        cyc(0, 0, 1, 10, 0, 4'b0100, 4'b0001, 0);
        cyc(0, 0, 0, 0, 0, '0, 4'b0010, 12);
        cyc(0, 0, 0, 0, 0, '0, 4'b0100, 5);
        cyc(1, 1, 0, 0, 0, '0, '0, 0);
        obs_clear();
        run(20, 1);
        chk("lim_ch0_hi", obs_hi[0], 0);
        chk("lim_ch1_hi", obs_hi[1], 20);
        chk("lim_ch2_hi", obs_hi[2], 10);

        // center mode P=5 D0=2
        cyc(0, 0, 1, 5, 1, 4'b0000, 4'b1111, 2);
        cyc(1, 1, 0, 0, 0, '0, '0, 0);
        obs_clear();
        run(20, 1);
        chk("ctr_hi_count", obs_hi[0], 8);
        chk("ctr_pe_count", obs_pe, 1);

        // enable stall mid-period
        run(3, 1);
        run(3, 0);
        run(12, 1);

        // async reset mid-period discards a pending shadow period
        cyc(1, 0, 1, 7, 0, 4'b1010, 4'b1111, 3);
        cyc(0, 0, 0, 0, 0, '0, '0, 0);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_pwm", int'(pwm_o), 0);
        chk("mid_rst_cnt", int'(cnt_o), 0);
        chk("mid_rst_prd_end", int'(prd_end_o), 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        mreset();
        cyc(1, 1, 0, 0, 0, '0, '0, 0);
        run(5, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit         r_en, r_clr, r_pwe, r_md;
            int         r_prd, r_d;
            bit [N-1:0] r_pl, r_dwe;
            r_en  = ($urandom_range(0, 9) != 0);
            r_clr = ($urandom_range(0, 59) == 0);
            r_pwe = ($urandom_range(0, 14) == 0);
            r_prd = int'($urandom_range(0, 12));
            r_md  = 1'($urandom_range(0, 1));
            r_pl  = N'($urandom);
            r_dwe = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            r_d   = int'($urandom_range(0, 15));
            cyc(r_en, r_clr, r_pwe, r_prd, r_md, r_pl, r_dwe, r_d);
        end
        cyc(0, 0, 0, 0, 0, '0, '0, 0);
        @(posedge clk_i);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
